// File: rtl/arm_defs_pkg.sv
// Shared definitions for the ARM memory stage: SRAM controller state encoding
// and the byte address at which the external SRAM is mapped.
package arm_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } sram_state_t;

  localparam logic [31:0] SRAM_BASE_ADDR = 32'd1024;

endpackage

// File: rtl/sram_controller.sv
// Splits one 32-bit MEM-stage load/store into two 16-bit accesses on the DE2
// SRAM, holding ready low so the pipeline freezes until both halves finish.
module sram_controller
  import arm_defs::*;
#(
  parameter logic [31:0] BASE_ADDR   = SRAM_BASE_ADDR,
  parameter int          HALF_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  localparam int            CW   = $clog2(HALF_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_CYCLES - 1);

  sram_state_t state, state_next;
  logic [CW-1:0] cnt;
  logic          op_write;
  logic [16:0]   word;
  logic [31:0]   wdata;
  logic [15:0]   low_half;
  logic          req;
  logic          last;
  logic          bus_active;
  logic          drive;

  assign req        = wr_en | rd_en;
  assign last       = (cnt == LAST);
  assign bus_active = (state == ST_LOW) || (state == ST_HIGH);
  assign drive      = bus_active && op_write;

  // DONE always falls back to IDLE so a request still held in DONE is not re-issued
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (req)  state_next = ST_LOW;
      ST_LOW:  if (last) state_next = ST_HIGH;
      ST_HIGH: if (last) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= (state_next != state) ? '0 : cnt + 1'b1;
    end
  end

  // read_data is written only once the high half arrives, so it never shows a torn word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_write  <= 1'b0;
      word      <= '0;
      wdata     <= '0;
      low_half  <= '0;
      read_data <= '0;
    end else begin
      if (state == ST_IDLE && req) begin
        op_write <= wr_en;
        word     <= 17'((address - BASE_ADDR) >> 2);
        wdata    <= write_data;
      end
      if (state == ST_LOW && last && !op_write)
        low_half <= SRAM_DQ;
      if (state == ST_HIGH && last && !op_write)
        read_data <= {SRAM_DQ, low_half};
    end
  end

  always_comb begin
    ready = 1'b0;
    case (state)
      ST_IDLE: ready = ~req;
      ST_DONE: ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  always_comb begin
    SRAM_ADDR = '0;
    if (state == ST_LOW)  SRAM_ADDR = {word, 1'b0};
    if (state == ST_HIGH) SRAM_ADDR = {word, 1'b1};
  end

  assign SRAM_DQ   = drive ? ((state == ST_HIGH) ? wdata[31:16] : wdata[15:0]) : 16'hzzzz;
  assign SRAM_WE_N = ~drive;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller: directed loads/stores against a
// behavioural 16-bit SRAM, with expectations checked by a separate monitor.
module tb_sram_controller;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n;
  logic        sram_ub_n;
  logic        sram_lb_n;
  logic        sram_ce_n;
  logic        sram_oe_n;

  logic [15:0] mem [0:262143];

  typedef struct {
    logic        is_write;
    logic [31:0] exp_rd;
    logic [17:0] lo_addr;
    logic [17:0] hi_addr;
    logic [15:0] lo_mem;
    logic [15:0] hi_mem;
    logic        b2b;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_done = 0;
  int seq_len  = 0;
  int we_cnt   = 0;
  logic [17:0] lo_seen;
  logic [17:0] hi_seen;

  sram_controller dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .SRAM_DQ    (sram_dq),
    .SRAM_ADDR  (sram_addr),
    .SRAM_WE_N  (sram_we_n),
    .SRAM_UB_N  (sram_ub_n),
    .SRAM_LB_N  (sram_lb_n),
    .SRAM_CE_N  (sram_ce_n),
    .SRAM_OE_N  (sram_oe_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: drives the bus whenever the controller is not writing
  assign sram_dq = sram_we_n ? mem[sram_addr] : 16'hzzzz;

  always @(posedge clk) begin
    if (!sram_we_n) mem[sram_addr] <= sram_dq;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Monitor: a DONE cycle is ready high while the request is still held
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      seq_len = 0;
      we_cnt  = 0;
    end else begin
      if (!sram_we_n) we_cnt++;
      if (wr_en || rd_en) begin
        if (!ready) begin
          seq_len++;
          if (seq_len == 2) lo_seen = sram_addr;
          if (seq_len == 4) hi_seen = sram_addr;
        end else begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            checkOutput("latency", 32'(seq_len), 32'd5);
            checkOutput("addr_lo", 32'(lo_seen), 32'(e.lo_addr));
            checkOutput("addr_hi", 32'(hi_seen), 32'(e.hi_addr));
            checkOutput("we_cycles", 32'(we_cnt), e.is_write ? 32'd4 : 32'd0);
            checkOutput("read_data", read_data, e.exp_rd);
            if (e.is_write) begin
              checkOutput("mem_lo", 32'(mem[e.lo_addr]), 32'(e.lo_mem));
              checkOutput("mem_hi", 32'(mem[e.hi_addr]), 32'(e.hi_mem));
            end
            if (e.b2b) checkOutput("b2b_gap", 32'(cyc - last_done), 32'd6);
          end
          last_done = cyc;
          seq_len   = 0;
          we_cnt    = 0;
        end
      end
    end
  end

  task automatic applyStimulus(input logic w, input logic r, input logic [31:0] addr,
                               input logic [31:0] data, input logic is_write,
                               input logic [31:0] exp_rd, input logic [17:0] lo,
                               input logic [17:0] hi, input logic [15:0] lo_mem,
                               input logic [15:0] hi_mem, input logic b2b, input logic keep);
    exp_t e;
    bit   done;
    e.is_write = is_write;
    e.exp_rd   = exp_rd;
    e.lo_addr  = lo;
    e.hi_addr  = hi;
    e.lo_mem   = lo_mem;
    e.hi_mem   = hi_mem;
    e.b2b      = b2b;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    wr_en      = w;
    rd_en      = r;
    address    = addr;
    write_data = data;
    done = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ready) begin
        done = 1;
        break;
      end
    end
    if (!done) checkOutput("ready_timeout", 32'd0, 32'd1);
    if (!keep) begin
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
    end
  endtask

  initial begin
    bit drained;
    for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;
    rst        = 1'b1;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    address    = 32'd0;
    write_data = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    checkOutput("reset_ready", 32'(ready), 32'd1);
    checkOutput("reset_we_n", 32'(sram_we_n), 32'd1);
    checkOutput("reset_read_data", read_data, 32'd0);
    checkOutput("reset_sram_addr", 32'(sram_addr), 32'd0);

    applyStimulus(1, 0, 32'd1024, 32'hDEADBEEF, 1, 32'h0, 18'h0, 18'h1, 16'hBEEF, 16'hDEAD, 0, 0);
    applyStimulus(0, 1, 32'd1024, 32'h0, 0, 32'hDEADBEEF, 18'h0, 18'h1, 16'h0, 16'h0, 0, 0);
    applyStimulus(1, 0, 32'd1032, 32'hA5A55A5A, 1, 32'hDEADBEEF, 18'h4, 18'h5, 16'h5A5A, 16'hA5A5, 0, 0);
    applyStimulus(1, 0, 32'd1020, 32'h0BADF00D, 1, 32'hDEADBEEF, 18'h3FFFE, 18'h3FFFF, 16'hF00D, 16'h0BAD, 0, 0);
    applyStimulus(0, 1, 32'd1020, 32'h0, 0, 32'h0BADF00D, 18'h3FFFE, 18'h3FFFF, 16'h0, 16'h0, 0, 0);
    applyStimulus(1, 1, 32'd1028, 32'h12345678, 1, 32'h0BADF00D, 18'h2, 18'h3, 16'h5678, 16'h1234, 0, 0);
    applyStimulus(1, 0, 32'd1036, 32'h55AA33CC, 1, 32'h0BADF00D, 18'h6, 18'h7, 16'h33CC, 16'h55AA, 0, 1);
    applyStimulus(0, 1, 32'd1036, 32'h0, 0, 32'h55AA33CC, 18'h6, 18'h7, 16'h0, 16'h0, 1, 0);

    // Store interrupted by reset while the high half is on the bus
    @(posedge clk);
    #1;
    wr_en      = 1'b1;
    address    = 32'd1040;
    write_data = 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("high_we_n_before_reset", 32'(sram_we_n), 32'd0);
    rst   = 1'b1;
    wr_en = 1'b0;
    #1;
    checkOutput("rst_we_n", 32'(sram_we_n), 32'd1);
    checkOutput("rst_read_data", read_data, 32'd0);
    checkOutput("rst_ready", 32'(ready), 32'd1);
    checkOutput("rst_sram_addr", 32'(sram_addr), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    applyStimulus(0, 1, 32'd1024, 32'h0, 0, 32'hDEADBEEF, 18'h0, 18'h1, 16'h0, 16'h0, 0, 0);

    drained = 0;
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0) begin
        drained = 1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("scoreboard_drained", 32'(drained), 32'd1);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
